// File: rtl/axis_pdm_ramp_pkg.sv
// rtl/axis_pdm_ramp_pkg.sv - shared types for the PDM setpoint ramp controller
package axis_pdm_ramp_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/axis_pdm_ramp.sv
// rtl/axis_pdm_ramp.sv - slews the axis_pdm sample stream toward a software target
module axis_pdm_ramp
  import axis_pdm_ramp_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = DEFAULT_WIDTH
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_target,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_step,
  input  logic                        cfg_start,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        sts_busy,
  output logic [AXIS_TDATA_WIDTH-1:0] sts_count
);

  localparam int W = AXIS_TDATA_WIDTH;

  logic [W-1:0] value;
  logic [W-1:0] target;
  logic [W-1:0] step;
  logic [W-1:0] count;
  logic         start_prev;
  logic         tvalid;
  state_t       state;

  logic                start_edge;
  logic                handshake;
  logic signed [W+1:0] diff;
  logic signed [W+1:0] mag;
  logic signed [W+1:0] step_ext;
  logic [W-1:0]        next_value;

  assign start_edge = cfg_start & ~start_prev;
  assign handshake  = tvalid & m_axis_tready;

  // Two guard bits keep target-value exact for any pair of W-bit signed levels.
  always_comb begin
    diff     = {{2{target[W-1]}}, target} - {{2{value[W-1]}}, value};
    mag      = diff[W+1] ? -diff : diff;
    step_ext = {2'b00, step};
    if (step == '0 || mag <= step_ext) begin
      next_value = target;
    end else if (!diff[W+1]) begin
      next_value = value + step;
    end else begin
      next_value = value - step;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      value      <= '0;
      target     <= '0;
      step       <= '0;
      count      <= '0;
      start_prev <= 1'b0;
      tvalid     <= 1'b0;
      state      <= ST_IDLE;
    end else begin
      start_prev <= cfg_start;
      tvalid     <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            target <= cfg_target;
            step   <= cfg_step;
            count  <= '0;
            state  <= ST_RAMP;
          end
        end
        ST_RAMP: begin
          // A coinciding handshake still steps with the old target/step.
          if (handshake && value != target) begin
            value <= next_value;
          end
          if (start_edge) begin
            target <= cfg_target;
            step   <= cfg_step;
            count  <= '0;
          end else if (value == target) begin
            state <= ST_IDLE;
          end else if (handshake && count != '1) begin
            count <= count + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = value;
  assign m_axis_tvalid = tvalid;
  assign sts_busy      = (state == ST_RAMP);
  assign sts_count     = count;

endmodule

// File: tb/tb_axis_pdm_ramp.sv
// tb/tb_axis_pdm_ramp.sv - self-checking bench for axis_pdm_ramp
module tb_axis_pdm_ramp;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] cfg_target;
  logic [15:0] cfg_step;
  logic        cfg_start;
  logic        m_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        sts_busy;
  logic [15:0] sts_count;

  axis_pdm_ramp #(.AXIS_TDATA_WIDTH(16)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_target    (cfg_target),
    .cfg_step      (cfg_step),
    .cfg_start     (cfg_start),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .sts_busy      (sts_busy),
    .sts_count     (sts_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int target;
    int step;
    int exp_count;
    int exp_cycles;
  } vec_t;

  vec_t vt[6];
  int   exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int model_next(input int v, input int t, input int s);
    int d;
    d = t - v;
    if (s == 0 || (d < 0 ? -d : d) <= s) return t;
    return (d > 0) ? v + s : v - s;
  endfunction

  // Every sample accepted while busy must match the next expected level.
  always @(negedge aclk) begin
    if (aresetn && sts_busy && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", $signed(m_axis_tdata), 99999);
      end else begin
        check("sb_sample", $signed(m_axis_tdata), exp_q.pop_front());
      end
    end
  end

  task automatic cyc;
    @(posedge aclk);
    #1;
  endtask

  task automatic push_ramp(input int from, input int t, input int s, output int n_upd);
    int v;
    v = from;
    n_upd = 0;
    for (int guard = 0; guard < 70000; guard++) begin
      exp_q.push_back(v);
      if (v == t) break;
      v = model_next(v, t, s);
      n_upd++;
    end
  endtask

  task automatic do_start(input int t, input int s);
    cfg_target = 16'(t);
    cfg_step   = 16'(s);
    cfg_start  = 1'b1;
    cyc();
    cfg_start  = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (sts_busy && n < 2000) begin
      cyc();
      n++;
    end
    check("idle_timeout", int'(sts_busy), 0);
  endtask

  initial begin
    int cur;
    int nu;
    int ncyc;
    int v;

    vt[0] = '{100,    30,     4, 5};
    vt[1] = '{32767,  0,      1, 2};
    vt[2] = '{-32768, 65535,  1, 2};
    vt[3] = '{5,      0,      1, 2};
    vt[4] = '{5,      7,      0, 1};
    vt[5] = '{-7,     3,      4, 5};

    aresetn       = 1'b0;
    cfg_target    = '0;
    cfg_step      = '0;
    cfg_start     = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) cyc();
    check("rst_tvalid", int'(m_axis_tvalid), 0);
    check("rst_tdata", int'(m_axis_tdata), 0);
    check("rst_busy", int'(sts_busy), 0);
    check("rst_count", int'(sts_count), 0);
    aresetn = 1'b1;
    cyc();
    check("rel_tvalid", int'(m_axis_tvalid), 1);
    check("rel_tdata", $signed(m_axis_tdata), 0);
    cur = 0;

    for (int i = 0; i < 6; i++) begin
      push_ramp(cur, vt[i].target, vt[i].step, nu);
      do_start(vt[i].target, vt[i].step);
      check("start_busy", int'(sts_busy), 1);
      wait_idle(ncyc);
      check("busy_cycles", ncyc, vt[i].exp_cycles);
      check("final_tdata", $signed(m_axis_tdata), vt[i].target);
      check("final_count", int'(sts_count), vt[i].exp_count);
      check("sb_drained", exp_q.size(), 0);
      cur = vt[i].target;
    end

    // Backpressure: freeze mid-ramp for 10 cycles.
    push_ramp(cur, 500, 50, nu);
    do_start(500, 50);
    repeat (3) cyc();
    m_axis_tready = 1'b0;
    v = cur;
    for (int k = 0; k < 3; k++) v = model_next(v, 500, 50);
    repeat (10) cyc();
    check("bp_tdata", $signed(m_axis_tdata), v);
    check("bp_count", int'(sts_count), 3);
    check("bp_busy", int'(sts_busy), 1);
    m_axis_tready = 1'b1;
    wait_idle(ncyc);
    check("bp_final_count", int'(sts_count), nu);
    check("bp_final_tdata", $signed(m_axis_tdata), 500);
    check("bp_drained", exp_q.size(), 0);

    push_ramp(500, 0, 0, nu);
    do_start(0, 0);
    wait_idle(ncyc);
    check("zero_tdata", $signed(m_axis_tdata), 0);

    // Retarget at 300 while the stream is stalled.
    exp_q.push_back(0);
    exp_q.push_back(100);
    exp_q.push_back(200);
    push_ramp(300, -50, 40, nu);
    do_start(1000, 100);
    repeat (3) cyc();
    check("rt_at300", $signed(m_axis_tdata), 300);
    m_axis_tready = 1'b0;
    do_start(-50, 40);
    m_axis_tready = 1'b1;
    check("rt_count_clr", int'(sts_count), 0);
    check("rt_busy", int'(sts_busy), 1);
    wait_idle(ncyc);
    check("rt_final_count", int'(sts_count), 9);
    check("rt_final_tdata", $signed(m_axis_tdata), -50);
    check("rt_drained", exp_q.size(), 0);

    // Reset in the middle of a ramp at value 400.
    for (int k = 0; k < 5; k++) exp_q.push_back(-50 + 90 * k);
    do_start(1000, 90);
    repeat (5) cyc();
    check("mr_at400", $signed(m_axis_tdata), 400);
    m_axis_tready = 1'b0;
    aresetn       = 1'b0;
    cyc();
    check("mr_tdata", int'(m_axis_tdata), 0);
    check("mr_busy", int'(sts_busy), 0);
    check("mr_tvalid", int'(m_axis_tvalid), 0);
    check("mr_count", int'(sts_count), 0);
    check("mr_drained", exp_q.size(), 0);
    aresetn       = 1'b1;
    m_axis_tready = 1'b1;
    cyc();
    check("mr_rel_tvalid", int'(m_axis_tvalid), 1);
    push_ramp(0, 100, 60, nu);
    do_start(100, 60);
    wait_idle(ncyc);
    check("mr_ramp_count", int'(sts_count), 2);
    check("mr_ramp_tdata", $signed(m_axis_tdata), 100);
    check("mr_ramp_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
